// File: rtl/morse_unit_timer.sv
// Morse unit timer: a prescaler of UNIT_CYCLES clocks drives a unit down-counter
// loaded from mult, with a start/busy/done handshake plus pause, abort and retrigger.
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 100,
  parameter int MULT_W      = 3,
  parameter int RETRIGGER   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MULT_W-1:0] mult,
  input  logic              pause,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              unit_tick,
  output logic [MULT_W-1:0] units_left
);

  localparam int TICK_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(UNIT_CYCLES - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic [MULT_W-1:0] units_q, units_d;
  logic              done_q, done_d;
  logic              tick_q, tick_d;
  logic              start_ok;

  // A start is taken in IDLE always, and in RUN only when retriggering is enabled.
  assign start_ok = start && ((state_q == S_IDLE) || (RETRIGGER != 0));

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    units_d = units_q;
    done_d  = 1'b0;
    tick_d  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      presc_d = '0;
      units_d = '0;
    end else if (start_ok) begin
      presc_d = '0;
      if (mult == '0) begin
        // Zero-length run (or retrigger to zero): finish immediately with a done.
        state_d = S_IDLE;
        units_d = '0;
        done_d  = 1'b1;
      end else begin
        state_d = S_RUN;
        units_d = mult;
      end
    end else if ((state_q == S_RUN) && !pause) begin
      if (presc_q == TICK_MAX) begin
        presc_d = '0;
        units_d = units_q - MULT_W'(1);
        tick_d  = 1'b1;
        if (units_q == MULT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end else begin
        presc_d = presc_q + TICK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      units_q <= '0;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      units_q <= units_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = done_q;
  assign unit_tick  = tick_q;
  assign units_left = units_q;

endmodule

// File: tb/tb_morse_unit_timer.sv
// Directed bench: three timer configurations share one stimulus; a vector table
// covers whole runs, hand sequences cover reset, traces and mid-run reset.
module tb_morse_unit_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] mult = '0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;

  // 0: UNIT_CYCLES=4 no retrigger, 1: UNIT_CYCLES=4 retrigger, 2: UNIT_CYCLES=1
  logic       busy_w [3];
  logic       done_w [3];
  logic       tick_w [3];
  logic [2:0] ul_w   [3];

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  morse_unit_timer #(.UNIT_CYCLES(4), .MULT_W(3), .RETRIGGER(0)) u_r0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mult(mult), .pause(pause), .abort(abort),
    .busy(busy_w[0]), .done(done_w[0]), .unit_tick(tick_w[0]), .units_left(ul_w[0]));
  morse_unit_timer #(.UNIT_CYCLES(4), .MULT_W(3), .RETRIGGER(1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mult(mult), .pause(pause), .abort(abort),
    .busy(busy_w[1]), .done(done_w[1]), .unit_tick(tick_w[1]), .units_left(ul_w[1]));
  morse_unit_timer #(.UNIT_CYCLES(1), .MULT_W(3), .RETRIGGER(0)) u_u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mult(mult), .pause(pause), .abort(abort),
    .busy(busy_w[2]), .done(done_w[2]), .unit_tick(tick_w[2]), .units_left(ul_w[2]));

  typedef struct {
    int sel;
    int mult;
    int pause_at;   // first edge (E0+k) that samples pause high
    int pause_len;
    int abort_at;   // edge E0+k that samples abort, -1 = none
    int rs_at;      // edge E0+k that samples a second start, -1 = none
    int rs_mult;
    int exp_done;   // k of the sample after which done is high, -1 = none
    int exp_ticks;
    int exp_busy;   // number of post-edge samples with busy high
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Drive inputs away from the edge, then sample 1 time unit after it.
  task automatic step(input bit s, input int m, input bit p, input bit a);
    @(negedge clk);
    start = s;
    mult  = 3'(m);
    pause = p;
    abort = a;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int first_done, n_done, n_tick, n_busy;
    bit s, p, a;
    int m;
    first_done = -1; n_done = 0; n_tick = 0; n_busy = 0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    for (int k = 0; k <= 30; k++) begin
      s = (k == 0) || (k == v.rs_at);
      m = (k == v.rs_at) ? v.rs_mult : v.mult;
      p = (k >= v.pause_at) && (k < v.pause_at + v.pause_len);
      a = (k == v.abort_at);
      step(s, m, p, a);
      if (done_w[v.sel]) begin
        if (first_done < 0) first_done = k;
        n_done++;
      end
      if (tick_w[v.sel]) n_tick++;
      if (busy_w[v.sel]) n_busy++;
    end
    chk($sformatf("v%0d_done_at", idx), first_done, v.exp_done);
    chk($sformatf("v%0d_done_count", idx), n_done, (v.exp_done < 0) ? 0 : 1);
    chk($sformatf("v%0d_ticks", idx), n_tick, v.exp_ticks);
    chk($sformatf("v%0d_busy_cycles", idx), n_busy, v.exp_busy);
    chk($sformatf("v%0d_units_end", idx), int'(ul_w[v.sel]), 0);
  endtask

  initial begin
    int first_done, n_bad;

    //          sel mult pat plen abrt rs  rsm done tk busy
    vecs[0] = '{0, 3, 0, 0, -1, -1, 0, 12, 3, 12};  // basic 3-unit run
    vecs[1] = '{0, 3, 6, 5, -1, -1, 0, 17, 3, 17};  // 5 paused edges push done out
    vecs[2] = '{0, 7, 0, 0,  7, -1, 0, -1, 1,  7};  // abort mid-run, no done
    vecs[3] = '{0, 0, 0, 0, -1, -1, 0,  0, 0,  0};  // mult=0: done right after E0
    vecs[4] = '{2, 2, 0, 0, -1, -1, 0,  2, 2,  2};  // one-cycle units
    vecs[5] = '{1, 3, 0, 0, -1,  5, 2, 13, 3, 13};  // retrigger reloads the run
    vecs[6] = '{0, 3, 0, 0, -1,  5, 2, 12, 3, 12};  // same start ignored
    vecs[7] = '{1, 3, 0, 0, -1,  5, 0,  5, 1,  5};  // retrigger to zero: abort + done
    vecs[8] = '{0, 3, 0, 0, -1, 12, 3, 12, 3, 12};  // start on completion edge ignored
    vecs[9] = '{0, 2, 2, 3,  3, -1, 0, -1, 0,  3};  // abort honoured during pause

    // Reset state, held low across several edges.
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_busy%0d", i), int'(busy_w[i]), 0);
      chk($sformatf("rst_done%0d", i), int'(done_w[i]), 0);
      chk($sformatf("rst_tick%0d", i), int'(tick_w[i]), 0);
      chk($sformatf("rst_units%0d", i), int'(ul_w[i]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // units_left / tick trace of a 3-unit run on the 4-cycle timer.
    step(0, 0, 0, 0);
    step(1, 3, 0, 0);
    chk("trace_k0_units", int'(ul_w[0]), 3);
    chk("trace_k0_busy", int'(busy_w[0]), 1);
    for (int k = 1; k <= 12; k++) begin
      step(0, 3, 0, 0);
      if (k == 3) chk("trace_k3_tick", int'(tick_w[0]), 0);
      if (k == 4) begin
        chk("trace_k4_tick", int'(tick_w[0]), 1);
        chk("trace_k4_units", int'(ul_w[0]), 2);
      end
      if (k == 8) chk("trace_k8_units", int'(ul_w[0]), 1);
      if (k == 11) chk("trace_k11_busy", int'(busy_w[0]), 1);
      if (k == 12) begin
        chk("trace_k12_units", int'(ul_w[0]), 0);
        chk("trace_k12_done", int'(done_w[0]), 1);
        chk("trace_k12_busy", int'(busy_w[0]), 0);
      end
    end
    step(0, 3, 0, 0);
    chk("trace_k13_done", int'(done_w[0]), 0);

    // Paused units_left holds at 2.
    step(1, 3, 0, 0);
    for (int k = 1; k <= 10; k++) step(0, 3, (k >= 6), 0);
    chk("pause_units_hold", int'(ul_w[0]), 2);
    chk("pause_no_tick", int'(tick_w[0]), 0);
    step(0, 0, 0, 1);

    // Abort together with start in IDLE stays idle.
    step(0, 0, 0, 0);
    step(1, 5, 0, 1);
    chk("abort_start_busy", int'(busy_w[0]), 0);
    chk("abort_start_done", int'(done_w[0]), 0);
    chk("abort_start_units", int'(ul_w[0]), 0);

    // Asynchronous reset mid-run: outputs clear without an edge.
    step(0, 0, 0, 0);
    step(1, 5, 0, 0);
    for (int k = 1; k <= 7; k++) step(0, 5, 0, 0);
    chk("prereset_units", int'(ul_w[0]), 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy_w[0]), 0);
    chk("async_rst_units", int'(ul_w[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_bad = 0;
    for (int k = 0; k < 25; k++) begin
      step(0, 0, 0, 0);
      if (done_w[0] || busy_w[0]) n_bad++;
    end
    chk("post_rst_quiet", n_bad, 0);
    first_done = -1;
    step(1, 1, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      step(0, 1, 0, 0);
      if (done_w[0] && first_done < 0) first_done = k;
    end
    chk("post_rst_mult1_done", first_done, 4);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
